// File: rtl/ext_ram_pkg.sv
// Shared types and saturation helpers for the banked extrinsic-message memory.
// The saturating adder works on 32-bit signed values so any DATA_WIDTH up to 31 can use it.
package ext_ram_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        ACC_WB = 2'd2
    } state_t;

    function automatic logic signed [31:0] sat_max(input logic signed [31:0] w);
        return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
    endfunction

    // Symmetric range: the most negative code is deliberately excluded.
    function automatic logic signed [31:0] sat_min(input logic signed [31:0] w);
        return -sat_max(w);
    endfunction

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input logic signed [31:0] w);
        logic signed [31:0] sum;
        sum = a + b;
        if (sum > sat_max(w))
            return sat_max(w);
        if (sum < sat_min(w))
            return sat_min(w);
        return sum;
    endfunction

endpackage

// File: rtl/RAM_SP_SR_RW.sv
// Generic single-port RAM, synchronous read, synchronous write.
// Read data register only updates on a read access.
module RAM_SP_SR_RW #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  cs,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (cs) begin
            if (we)
                mem[addr] <= din;
            else
                dout <= mem[addr];
        end
    end

endmodule

// File: rtl/ext_ram_banked.sv
// N_LANES-wide extrinsic-message memory with per-lane write enables, saturating
// read-modify-write accumulate and a clear sequencer that zeroes the array.
module ext_ram_banked
    import ext_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int N_LANES    = 4,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          cs,
    input  logic                          we,
    input  logic                          acc,
    input  logic [N_LANES-1:0]            lane_en,
    input  logic [ADDR_WIDTH-1:0]         address,
    input  logic [N_LANES*DATA_WIDTH-1:0] data_in,
    output logic [N_LANES*DATA_WIDTH-1:0] data_out,
    output logic                          rd_valid,
    output logic                          ready
);

    localparam int WORD_W = N_LANES * DATA_WIDTH;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    clr_last;
    logic                    req_ok;
    logic                    acc_start;
    logic                    rd_start;

    logic [ADDR_WIDTH-1:0]   acc_addr_p1;
    logic [N_LANES-1:0]      acc_en_p1;
    logic [WORD_W-1:0]       acc_data_p1;

    logic                    vld_p1;
    logic [WORD_W-1:0]       rd_hold_p1;
    logic [WORD_W-1:0]       rd_word;
    logic [ADDR_WIDTH-1:0]   ram_addr;

    assign ready     = (state == IDLE);
    assign req_ok    = ready && cs && !clear;
    assign acc_start = req_ok && we && acc;
    assign rd_start  = req_ok && !we;
    assign clr_last  = (clr_cnt == ADDR_WIDTH'(RAM_DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            else if (ready && clear)
                clr_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_last) state_nxt = IDLE;
            IDLE: begin
                if (clear)
                    state_nxt = CLEAR;
                else if (acc_start)
                    state_nxt = ACC_WB;
            end
            ACC_WB:  state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    // ---- p0 -> p1: accumulate capture (data regs need no reset) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_en_p1 <= '0;
        else if (acc_start)
            acc_en_p1 <= lane_en;
    end

    always_ff @(posedge clk) begin
        if (acc_start) begin
            acc_addr_p1 <= address;
            acc_data_p1 <= data_in;
        end
    end

    always_comb begin
        ram_addr = address;
        case (state)
            CLEAR:   ram_addr = clr_cnt;
            ACC_WB:  ram_addr = acc_addr_p1;
            default: ram_addr = address;
        endcase
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic                         l_cs;
        logic                         l_we;
        logic        [DATA_WIDTH-1:0] l_din;
        logic        [DATA_WIDTH-1:0] l_dout;
        logic signed [DATA_WIDTH-1:0] l_stored;
        logic signed [DATA_WIDTH-1:0] l_addend;
        logic signed [DATA_WIDTH-1:0] l_sum;

        // The RAM read register still holds the word fetched in the accumulate's first cycle.
        assign l_stored = l_dout;
        assign l_addend = acc_data_p1[i*DATA_WIDTH +: DATA_WIDTH];
        assign l_sum    = DATA_WIDTH'(sat_add(32'(l_stored), 32'(l_addend), DATA_WIDTH));
        assign rd_word[i*DATA_WIDTH +: DATA_WIDTH] = l_dout;

        always_comb begin
            l_cs  = 1'b0;
            l_we  = 1'b0;
            l_din = '0;
            case (state)
                CLEAR: begin
                    l_cs = 1'b1;
                    l_we = 1'b1;
                end
                IDLE: begin
                    if (req_ok) begin
                        if (!we || acc) begin
                            l_cs = 1'b1;
                        end else if (lane_en[i]) begin
                            l_cs  = 1'b1;
                            l_we  = 1'b1;
                            l_din = data_in[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                ACC_WB: begin
                    if (acc_en_p1[i]) begin
                        l_cs  = 1'b1;
                        l_we  = 1'b1;
                        l_din = l_sum;
                    end
                end
                default: ;
            endcase
        end

        RAM_SP_SR_RW #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .RAM_DEPTH  (RAM_DEPTH)
        ) u_ram (
            .clk  (clk),
            .cs   (l_cs),
            .we   (l_we),
            .addr (ram_addr),
            .din  (l_din),
            .dout (l_dout)
        );
    end

    // ---- p1: read completion; hold register keeps data_out stable across clears/accumulates ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            rd_hold_p1 <= '0;
        end else begin
            vld_p1 <= rd_start;
            if (vld_p1)
                rd_hold_p1 <= rd_word;
        end
    end

    assign rd_valid = vld_p1;
    assign data_out = vld_p1 ? rd_word : rd_hold_p1;

endmodule

// File: tb/tb_ext_ram_banked.sv
// Directed bench for ext_ram_banked with a read-data scoreboard.
module tb_ext_ram_banked;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        cs;
    logic        we;
    logic        acc;
    logic [3:0]  lane_en;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        ready;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    ext_ram_banked #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .N_LANES    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .cs       (cs),
        .we       (we),
        .acc      (acc),
        .lane_en  (lane_en),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rd_valid must match the oldest pending read, in the cycle after issue.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL rd_valid_unexpected observed 1 expected 0 at cycle %0d", cyc);
            end
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rd_data", data_out, e.data);
                chk("rd_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        cs      = 1'b0;
        we      = 1'b0;
        acc     = 1'b0;
        clear   = 1'b0;
        lane_en = '0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        exp_t x;
        cs      = 1'b1;
        we      = 1'b0;
        acc     = 1'b0;
        address = a;
        x.data  = e;
        x.due   = cyc + 1;
        sb_q.push_back(x);
        tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] en);
        cs      = 1'b1;
        we      = 1'b1;
        acc     = 1'b0;
        address = a;
        data_in = d;
        lane_en = en;
        tick();
    endtask

    task automatic ac(input logic [7:0] a, input logic [31:0] d, input logic [3:0] en);
        cs      = 1'b1;
        we      = 1'b1;
        acc     = 1'b1;
        address = a;
        data_in = d;
        lane_en = en;
        tick();
        chk("acc_busy_ready", 32'(ready), 32'd0);
        idle_in();
        tick();
        chk("acc_done_ready", 32'(ready), 32'd1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        data_in = '0;
        address = '0;
        idle_in();
        tick();
        tick();
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_data_out", data_out, 32'd0);

        rst_n = 1'b1;
        wait_ready(n);
        chk("init_clear_cycles", 32'(n), 32'd256);

        rd(8'd0, 32'd0);
        rd(8'd17, 32'd0);
        idle_in();
        tick();
        rd(8'd255, 32'd0);
        idle_in();
        tick();

        // masked write
        wr(8'd5, pk(10, 20, 30, 40), 4'b0101);
        idle_in();
        rd(8'd5, pk(10, 0, 30, 0));
        idle_in();
        tick();

        // accumulate with saturation at both ends and a disabled lane
        wr(8'd7, pk(100, -100, 3, 0), 4'b1111);
        ac(8'd7, pk(50, -50, -5, 77), 4'b0111);
        rd(8'd7, pk(127, -127, -2, 0));
        idle_in();
        tick();

        // most negative code written directly is kept; accumulating clamps to -127
        wr(8'd8, pk(-128, 0, 0, 0), 4'b0001);
        idle_in();
        rd(8'd8, pk(-128, 0, 0, 0));
        idle_in();
        ac(8'd8, pk(-1, 0, 0, 0), 4'b0001);
        rd(8'd8, pk(-127, 0, 0, 0));
        idle_in();
        tick();

        // write then immediate read, then four back-to-back reads
        wr(8'd9, pk(1, 2, 3, 4), 4'b1111);
        rd(8'd9, pk(1, 2, 3, 4));
        rd(8'd5, pk(10, 0, 30, 0));
        rd(8'd7, pk(127, -127, -2, 0));
        rd(8'd0, 32'd0);
        rd(8'd9, pk(1, 2, 3, 4));
        idle_in();
        tick();
        tick();
        chk("sb_drain_1", 32'(sb_q.size()), 32'd0);

        // clear together with a read: read dropped, data_out held, array zeroed
        cs      = 1'b1;
        we      = 1'b0;
        address = 8'd5;
        clear   = 1'b1;
        tick();
        idle_in();
        wait_ready(n);
        chk("clear_cycles", 32'(n), 32'd256);
        chk("clear_holds_data_out", data_out, pk(1, 2, 3, 4));
        rd(8'd9, 32'd0);
        rd(8'd5, 32'd0);
        rd(8'd7, 32'd0);
        idle_in();
        tick();

        // reset during accumulate write-back
        wr(8'd3, pk(5, 5, 5, 5), 4'b1111);
        idle_in();
        rd(8'd3, pk(5, 5, 5, 5));
        idle_in();
        tick();
        cs      = 1'b1;
        we      = 1'b1;
        acc     = 1'b1;
        address = 8'd3;
        data_in = pk(1, 1, 1, 1);
        lane_en = 4'b1111;
        tick();
        chk("accwb_ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        idle_in();
        #2;
        chk("midrst_data_out", data_out, 32'd0);
        chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        chk("postrst_clear_cycles", 32'(n), 32'd256);
        rd(8'd3, 32'd0);
        idle_in();
        tick();
        tick();
        chk("sb_drain_2", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_ram_banked.md
# ext_ram_banked

Multi-lane extrinsic-message memory for the LDPC decoder. It stores N_LANES independent signed messages per address, one per circulant lane. Each lane has its own write enable, and there is a read-modify-write accumulate mode with symmetric saturation. A built-in clear sequencer zeroes the whole array after reset and on request, so check/variable-node units never read uninitialised extrinsics.

## Interface
- DATA_WIDTH, 8, bits per lane message (signed two's complement)
- ADDR_WIDTH, 8, address bits
- N_LANES, 4, parallel lanes per word
- RAM_DEPTH, 1<<ADDR_WIDTH, words per lane

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  start full-array clear; sampled only when ready=1
- cs  in  1  request valid; accepted when cs && ready
- we  in  1  1 = write/accumulate, 0 = read
- acc  in  1  with we=1: stored += data_in (saturating); ignored when we=0
- lane_en  in  N_LANES  per-lane write/accumulate enable
- address  in  ADDR_WIDTH  word address
- data_in  in  N_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- data_out  out  N_LANES*DATA_WIDTH  registered read data, same packing
- rd_valid  out  1  one-cycle pulse: data_out holds the newly read word
- ready  out  1  block can accept a request this cycle

## Operation
- States:
  - CLEAR: writes zero to address clr_cnt in all lanes, one address per cycle; exits to IDLE after RAM_DEPTH-1.
  - IDLE: accepts requests.
  - ACC_WB: accumulate write-back cycle.
- IDLE priority when ready=1: clear over cs. clear together with cs enters CLEAR and drops the request.
- Read (cs, !we): all lanes are read at address. data_out and rd_valid update the next cycle. lane_en is ignored.
- Write (cs, we, !acc): lanes with lane_en[i]=1 store data_in lane i. Other lanes are unchanged.
- Accumulate (cs, we, acc):
  - Cycle 0 reads address and latches data_in, lane_en and address.
  - Cycle 1 (ACC_WB) writes sat(stored+data_in) to enabled lanes and returns to IDLE.
  - Accumulate does not assert rd_valid.
- Saturation: compute the sum in DATA_WIDTH+1 bits, then clamp to [-(2^(DATA_WIDTH-1)-1), +(2^(DATA_WIDTH-1)-1)]. The most negative code is never produced.
- Stored values of -2^(DATA_WIDTH-1) written directly are kept as is. Saturation applies only on accumulate.
- A lane with lane_en=0 is never modified by write or accumulate.

## Timing
- Reset values: data_out=0, rd_valid=0, ready=0, state=CLEAR, clr_cnt=0.
- After rst_n release, CLEAR runs for RAM_DEPTH cycles. ready rises on the cycle after the last clear write.
- Read latency is 1 cycle. Back-to-back reads sustain 1 per cycle.
- A read in the cycle after a write or accumulate write-back to the same address returns the new value; no bypass is needed.
- Accumulate occupies 2 cycles. ready=0 in ACC_WB. Accumulates to any address issue every 2 cycles.
- The clear request takes RAM_DEPTH cycles with ready=0. clear asserted while ready=0 is ignored.
- data_out holds its last read value until the next read completes. Clear does not change data_out.
- rst_n asserted mid-operation, at any state including ACC_WB or CLEAR: immediate return to reset values. The pending write-back is discarded and a full clear follows release.

## Structure
- Package ext_ram_pkg: state enum {CLEAR, IDLE, ACC_WB}; function sat_add(a,b) parameterised by DATA_WIDTH; SAT_MAX/SAT_MIN derivation.
- Storage: N_LANES instances of the existing generic RAM_SP_SR_RW. Each is DATA_WIDTH wide and RAM_DEPTH deep, with per-lane cs/we derived from lane_en and FSM state.
- The FSM, clear counter, accumulate capture registers and saturating adders live in the top module. No other sub-module.

## Test plan
- Reset release: ready=0 for exactly 256 cycles (defaults), then 1. Reading addresses 0, 17 and 255 returns all lanes 0, with rd_valid one cycle after each cs.
- Masked write: address 5, data_in lanes {10,20,30,40}, lane_en=4'b0101. A read of 5 returns {10,0,30,0}.
- Accumulate saturation (DATA_WIDTH=8):
  - Lane 0 holds 100; accumulate +50 gives 127.
  - Lane 1 holds -100; accumulate -50 gives -127.
  - Lane 2 holds 3; accumulate -5 gives -2.
  - ready is 0 for exactly 1 cycle after each accumulate.
- Back-to-back: write address 9 = {1,2,3,4}, then next-cycle read of 9 returns {1,2,3,4}. Four consecutive reads produce four consecutive rd_valid pulses.
- Clear with cs in the same cycle: the request is dropped. ready=0 for 256 cycles, then all previously written data reads 0.
- rst_n pulsed during ACC_WB of address 3: the write-back does not occur. After the post-reset clear, address 3 reads 0.
